// File: rtl/td4_pkg.sv
// Shared types and constants for the TD4 writable program store.
package td4_pkg;

    // Loader sequencing states.
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // TD4 opcodes used by the power-on image.
    localparam logic [7:0] OP_IN_B  = 8'h60;
    localparam logic [7:0] OP_OUT_B = 8'h90;
    localparam logic [7:0] OP_JMP_0 = 8'hF0;
    localparam logic [7:0] OP_FILL  = 8'hFF;

    // Power-on program: echo input port B to output port B forever.
    localparam logic [7:0] DEFAULT_IMAGE [0:15] = '{
        OP_IN_B, OP_OUT_B, OP_JMP_0, OP_FILL,
        OP_FILL, OP_FILL,  OP_FILL,  OP_FILL,
        OP_FILL, OP_FILL,  OP_FILL,  OP_FILL,
        OP_FILL, OP_FILL,  OP_FILL,  OP_FILL
    };

    // Default word for any address; words beyond the 16-entry image are filler.
    function automatic logic [7:0] default_word(input int idx);
        if (idx >= 0 && idx < 16) begin
            return DEFAULT_IMAGE[idx];
        end
        return OP_FILL;
    endfunction

endpackage

// File: rtl/prog_mem_16x8.sv
// Program store: flop array reset to the default image, one synchronous
// write port and one combinational read port.
module prog_mem_16x8
    import td4_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wadr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] radr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 2**AW;

    logic [DEPTH-1:0][DW-1:0] w_words;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [DW-1:0] r_word;

            // Each word restores its default opcode on reset and captures
            // write data only when addressed.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_word <= DW'(default_word(gi));
                end else if (we && (wadr == AW'(gi))) begin
                    r_word <= wdata;
                end
            end

            assign w_words[gi] = r_word;
        end
    endgenerate

    // Zero-latency fetch, as the old ROM provided.
    assign rdata = w_words[radr];

endmodule

// File: rtl/prog_loader.sv
// Writable program store with byte-stream loader: holds the core while a
// new image plus optional checksum is streamed in, then releases it.
module prog_loader
    import td4_pkg::*;
#(
    parameter int AW       = 4,
    parameter int DW       = 8,
    parameter int USE_CSUM = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] cpu_adr,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_hold,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          ld_done,
    output logic          ld_err
);

    localparam int DEPTH = 2**AW;
    localparam int CW    = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [DW-1:0] r_sum;
    logic [DW-1:0] w_sum_next;
    logic          r_err;
    logic          w_err_next;
    logic          w_we;
    logic [AW-1:0] w_wadr;

    prog_mem_16x8 #(
        .AW (AW),
        .DW (DW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we),
        .wadr  (w_wadr),
        .wdata (ld_data),
        .radr  (cpu_adr),
        .rdata (cpu_dout)
    );

    // State, byte counter, running checksum and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_sum   <= w_sum_next;
            r_err   <= w_err_next;
        end
    end

    // Next-state decode; a start request always wins over a coincident byte.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_sum_next   = r_sum;
        w_err_next   = r_err;
        w_we         = 1'b0;
        w_wadr       = r_cnt[AW-1:0];
        case (r_state)
            RUN: begin
                if (ld_start) begin
                    w_state_next = LOAD;
                    w_cnt_next   = '0;
                    w_sum_next   = '0;
                    w_err_next   = 1'b0;
                end
            end
            LOAD: begin
                if (ld_start) begin
                    w_cnt_next = '0;
                    w_sum_next = '0;
                end else if (ld_valid) begin
                    if (r_cnt < CNT_FULL) begin
                        w_we       = 1'b1;
                        w_sum_next = r_sum + ld_data;
                        w_cnt_next = r_cnt + CW'(1);
                        if ((USE_CSUM == 0) && (r_cnt == CNT_LAST)) begin
                            w_state_next = DONE;
                        end
                    end else if (USE_CSUM != 0) begin
                        if (ld_data == r_sum) begin
                            w_state_next = DONE;
                        end else begin
                            w_state_next = ERR;
                            w_err_next   = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                w_state_next = RUN;
            end
            ERR: begin
                if (ld_start) begin
                    w_state_next = LOAD;
                    w_cnt_next   = '0;
                    w_sum_next   = '0;
                    w_err_next   = 1'b0;
                end
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    // Handshake and hold outputs come straight from the registered state.
    assign cpu_hold = (r_state != RUN);
    assign ld_ready = (r_state == LOAD);
    assign ld_done  = (r_state == DONE);
    assign ld_err   = r_err;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writable 16x8 program store that replaces the fixed instruction ROM. It sits between the TD4 core's fetch port and a byte-stream loader port.
- In RUN it serves instruction fetches with zero latency, like the ROM did.
- In LOAD it holds the core, accepts 16 instruction bytes and a checksum byte over a valid/ready handshake, and releases the core when the checksum matches.

Parameters:
- AW, 4, address width; depth = 2**AW.
- DW, 8, instruction width.
- USE_CSUM, 1, 1 = expect a trailing checksum byte; 0 = finish after the last data byte.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_adr  in  AW  fetch address from the core's PC.
- cpu_dout  out  DW  instruction at cpu_adr (combinational).
- cpu_hold  out  1  freeze/reset request to the core.
- ld_start  in  1  request to begin or restart a load.
- ld_valid  in  1  loader byte valid.
- ld_data  in  DW  loader byte.
- ld_ready  out  1  block accepts a byte this cycle.
- ld_done  out  1  one-cycle pulse on successful load.
- ld_err  out  1  sticky checksum-failure flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = RUN; cpu_hold = 0; ld_ready = 0; ld_done = 0; ld_err = 0; cnt = 0; sum = 0.
  - Memory reloads the default image: addr 0 = 8'h60 (IN B), 1 = 8'h90 (OUT B), 2 = 8'hF0 (JMP 0), 3..15 = 8'hFF.
- Reads: cpu_dout = mem[cpu_adr] in every state, with zero cycles of latency.
- States:
  - RUN: cpu_hold = 0, ld_ready = 0. ld_start goes to LOAD next cycle with cnt = 0, sum = 0.
  - LOAD: cpu_hold = 1, ld_ready = 1, ld_err cleared on entry. A byte transfers only when ld_valid && ld_ready.
    - cnt < 2**AW: write mem[cnt] = ld_data; sum += ld_data (mod 2**DW); cnt++.
    - cnt == 2**AW and USE_CSUM = 1: the byte is the checksum. ld_data == sum goes to DONE; otherwise go to ERR and set ld_err = 1.
    - USE_CSUM = 0: the transfer that writes the last address (cnt == 2**AW-1) goes to DONE.
  - DONE: exactly one cycle. cpu_hold = 1, ld_done = 1, ld_ready = 0. Next state is RUN.
  - ERR: cpu_hold = 1, ld_ready = 0, ld_err stays 1. Memory keeps the partially or wrongly loaded image. Only ld_start leaves ERR: go to LOAD, clear ld_err.
- Counter: cnt is AW+1 bits wide and never wraps. No write occurs when cnt == 2**AW.
- ld_start during LOAD restarts the load: cnt = 0, sum = 0. A byte presented in the same cycle is dropped (not written). Already-written addresses keep their new contents.
- ld_start during DONE is ignored.
- ld_valid outside LOAD is ignored, with no side effects.
- Asynchronous reset mid-LOAD aborts immediately. The default image is restored and the core is released (cpu_hold = 0).
- cpu_hold, ld_ready and ld_done are decoded from the registered state only, so they are glitch-free and depend on no inputs.

Decomposition:
- Package td4_pkg:
  - state enum {RUN, LOAD, DONE, ERR}.
  - Opcode constants OP_IN_B = 8'h60, OP_OUT_B = 8'h90, OP_JMP_0 = 8'hF0, OP_FILL = 8'hFF.
  - DEFAULT_IMAGE array constant.
- Sub-module prog_mem_16x8:
  - Flop array with async reset to DEFAULT_IMAGE.
  - One synchronous write port (we, wadr, wdata) and one combinational read port.
- prog_loader holds the FSM, the counter and the checksum.

Test Plan:
- Reset, then sweep cpu_adr 0..15 -> cpu_dout = 60, 90, F0, then FF x13; cpu_hold = 0; ld_ready = 0.
- Pulse ld_start; send bytes 0x01..0x10 then checksum 0x88 (sum of 1..16 = 136), with ld_valid held high -> ld_ready high for 17 cycles, ld_done a single pulse, cpu_hold drops one cycle later, mem[i] = i+1.
- Same load with checksum 0x89 -> state ERR, ld_err = 1, cpu_hold stays 1. A new ld_start clears ld_err and ld_ready rises next cycle.
- Insert random ld_valid gaps of 0-3 cycles during a load of sixteen 0x11 bytes with checksum 0x10 -> identical memory contents and ld_done.
- Assert ld_start after 5 bytes (0xAA each), then load 16 bytes of 0x00 with checksum 0x00 -> mem all 00; the byte coincident with ld_start is not written.
- Assert rst after 8 bytes of a load -> cpu_hold = 0 asynchronously, memory back to the default image, state RUN.
